// File: rtl/i2c_line_filter.sv
// I2C pad conditioner: synchronises raw SCL/SDA, rejects short glitches, and reports
// filtered levels, edge pulses, START/STOP events and a bus-busy flag.
module i2c_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_o,
    output logic sda_o,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_rise,
    output logic sda_fall,
    output logic start_det,
    output logic stop_det,
    output logic bus_busy
);

    localparam int              CW      = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(FILTER_LEN - 1);
    localparam int              SCL     = 0;
    localparam int              SDA     = 1;

    logic [SYNC_STAGES-1:0] r_sync [2];
    logic [CW-1:0]          r_cnt  [2];
    logic [1:0]             r_filt;
    logic [1:0]             r_rise;
    logic [1:0]             r_fall;
    logic                   r_start;
    logic                   r_stop;
    logic                   r_busy;

    logic [1:0]             w_raw;
    logic [1:0]             w_synced;
    logic [1:0]             w_commit;
    logic                   w_start;
    logic                   w_stop;

    assign w_raw = {sda_i, scl_i};

    // A line commits when the synced sample has disagreed for FILTER_LEN consecutive edges.
    for (genvar g = 0; g < 2; g++) begin : g_line
        assign w_synced[g] = r_sync[g][SYNC_STAGES-1];
        assign w_commit[g] = (w_synced[g] != r_filt[g]) && (r_cnt[g] == CNT_MAX);
    end

    // START/STOP are judged against the SCL level before this edge, and only when SCL is stable.
    assign w_start = w_commit[SDA] && !w_synced[SDA] && r_filt[SCL] && !w_commit[SCL];
    assign w_stop  = w_commit[SDA] &&  w_synced[SDA] && r_filt[SCL] && !w_commit[SCL];

    // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: these small per-line arrays are plain flops, so resetting them is legal and cheap.
            for (int i = 0; i < 2; i++) begin
                r_sync[i] <= '1;
                r_cnt[i]  <= '0;
            end
            r_filt  <= 2'b11;
            r_rise  <= 2'b00;
            r_fall  <= 2'b00;
            r_start <= 1'b0;
            r_stop  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_raw[i]};
                if (w_synced[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_commit[i]) begin
                    r_filt[i] <= w_synced[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
                r_rise[i] <= w_commit[i] &&  w_synced[i];
                r_fall[i] <= w_commit[i] && !w_synced[i];
            end
            r_start <= w_start;
            r_stop  <= w_stop;
            if (w_start) begin
                r_busy <= 1'b1;
            end else if (w_stop) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign scl_o     = r_filt[SCL];
    assign sda_o     = r_filt[SDA];
    assign scl_rise  = r_rise[SCL];
    assign scl_fall  = r_fall[SCL];
    assign sda_rise  = r_rise[SDA];
    assign sda_fall  = r_fall[SDA];
    assign start_det = r_start;
    assign stop_det  = r_stop;
    assign bus_busy  = r_busy;

endmodule
